// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester byte scheduler in front of the shared UART
// transmitter. Each requester writes into its own circular FIFO. One FSM picks
// a head byte, presents it on tx_data, pulses tx_we for one cycle, then paces
// the next issue on the UART's tx_busy. A timeout covers a busy pulse that
// never shows up.
//
// Build option:
//   UART_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a conflict
//                            and requester 1 is served only while FIFO 0 is
//                            empty. When undefined (default), conflicts
//                            alternate using last_grant.
//
// Handshake semantics:
//   reqN_we / reqN_full : a write is accepted on a rising edge where reqN_we=1
//                         and reqN_full=0. A write while full is discarded and
//                         latches drop[N] until reset. There is no backpressure
//                         beyond the full flag.
//   tx_we / tx_busy     : tx_we is a single-cycle issue strobe qualifying
//                         tx_data. After it, the arbiter waits for tx_busy to
//                         rise (bounded by BUSY_WAIT cycles) and then to fall
//                         before it issues again. tx_busy is ignored in IDLE.
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int BUSY_WAIT  = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] req0_data,
    input  logic       req0_we,
    output logic       req0_full,
    input  logic [7:0] req1_data,
    input  logic       req1_we,
    output logic       req1_full,
    output logic [7:0] tx_data,
    output logic       tx_we,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic [1:0] drop,
    output logic       idle,
    output logic [1:0] state_dbg
);

    // Pointer width wraps naturally because FIFO_DEPTH is a power of two.
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WW = (BUSY_WAIT > 0) ? $clog2(BUSY_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RISE = 2'd2,
        S_WAIT_FALL = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [WW-1:0]   wait_cnt;
    logic [WW-1:0]   wait_cnt_n;

    logic [1:0]      full;
    logic [1:0]      empty;
    logic [1:0]      pop;
    logic [1:0][7:0] head;
    logic            sel;
    logic            do_grant;

    // ------------------------------------------------------------------
    // Per-requester FIFOs
    // ------------------------------------------------------------------
    for (genvar n = 0; n < 2; n++) begin : g_fifo
        logic [7:0]    mem [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [CW-1:0] count;
        logic [7:0]    wdat;
        logic          we;
        logic          push;
        logic          drop_q;

        assign wdat     = (n == 0) ? req0_data : req1_data;
        assign we       = (n == 0) ? req0_we : req1_we;
        assign full[n]  = (count == CW'(FIFO_DEPTH));
        assign empty[n] = (count == '0);
        // A write while full is discarded even if this FIFO pops in the same cycle.
        assign push     = we && !full[n];
        assign head[n]  = mem[rd_ptr];
        assign drop[n]  = drop_q;

        // Storage array; contents need no reset because count gates every read.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= wdat;
            end
        end

        // Pointers and occupancy; a simultaneous push and pop leave count unchanged.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop[n]) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop[n]})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end

        // Sticky overflow flag, cleared only by reset.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                drop_q <= 1'b0;
            end else if (we && full[n]) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign req0_full = full[0];
    assign req1_full = full[1];

`ifndef UART_ARB_FIXED_PRIO_EN
    // Remembers who was served last so a conflict goes to the other requester.
    logic last_grant;

    // Round-robin history; reset to 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (do_grant) begin
            last_grant <= sel;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------

    // Next-state, requester selection and wait-counter update.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        pop        = 2'b00;
        do_grant   = 1'b0;
        sel        = 1'b0;
        case (state)
            S_IDLE: begin
                if (empty != 2'b11) begin
                    do_grant = 1'b1;
`ifdef UART_ARB_FIXED_PRIO_EN
                    sel = empty[0];
`else
                    if (empty == 2'b00) begin
                        sel = ~last_grant;
                    end else begin
                        sel = empty[0];
                    end
`endif
                    pop     = sel ? 2'b10 : 2'b01;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_n = WW'(BUSY_WAIT);
                state_n    = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                // The counter bounds the wait in case the busy pulse is missed.
                if (tx_busy) begin
                    state_n = S_WAIT_FALL;
                end else if (wait_cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    wait_cnt_n = wait_cnt - WW'(1);
                end
            end
            S_WAIT_FALL: begin
                if (!tx_busy) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State register plus the latched byte and grant that go with each issue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            tx_data  <= 8'h00;
            grant_id <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            if (do_grant) begin
                tx_data  <= head[sel];
                grant_id <= sel;
            end
        end
    end

    assign tx_we     = (state == S_ISSUE);
    assign idle      = (state == S_IDLE) && (empty == 2'b11);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte latency, round-robin order,
// overflow, busy timeout pacing, asynchronous reset and pointer wrap-around.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int FIFO_DEPTH = 4;
    localparam int BUSY_WAIT  = 3;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk     = 1'b0;
    logic       resetn  = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_we   = 1'b0;
    logic       req0_full;
    logic [7:0] req1_data = 8'h00;
    logic       req1_we   = 1'b0;
    logic       req1_full;
    logic [7:0] tx_data;
    logic       tx_we;
    logic       tx_busy = 1'b0;
    logic       grant_id;
    logic [1:0] drop;
    logic       idle;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .BUSY_WAIT (BUSY_WAIT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req0_data(req0_data),
        .req0_we  (req0_we),
        .req0_full(req0_full),
        .req1_data(req1_data),
        .req1_we  (req1_we),
        .req1_full(req1_full),
        .tx_data  (tx_data),
        .tx_we    (tx_we),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .drop     (drop),
        .idle     (idle),
        .state_dbg(state_dbg)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    logic [7:0] log_data[$];
    logic       log_gid[$];
    int         log_cyc[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         busy_len = 0;

    // Issue monitor: records every tx_we pulse with its byte, grant and cycle.
    always @(negedge clk) begin
        if (tx_we) begin
            log_data.push_back(tx_data);
            log_gid.push_back(grant_id);
            log_cyc.push_back(cyc);
        end
    end

    // UART busy model: high for busy_len cycles starting one cycle after an issue.
    always @(negedge clk) begin
        if (tx_we && busy_len > 0) begin
            @(negedge clk);
            tx_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            tx_busy = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Driver / checker tasks
    // ------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_gid.delete();
        log_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        req0_we = 1'b0;
        req1_we = 1'b0;
        resetn  = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
        clear_logs();
    endtask

    task automatic wr0(input logic [7:0] d);
        req0_data = d;
        req0_we   = 1'b1;
        step();
        req0_we   = 1'b0;
    endtask

    task automatic wr1(input logic [7:0] d);
        req1_data = d;
        req1_we   = 1'b1;
        step();
        req1_we   = 1'b0;
    endtask

    // Wait until n bytes have been issued and the block is idle again.
    task automatic wait_issued(input int n, input int max_cyc);
        int k = 0;
        while (!(log_data.size() >= n && idle) && k < max_cyc) begin
            step();
            k++;
        end
        if (k >= max_cyc) check_eq("wait_timeout", 32'(log_data.size()), 32'(n));
    endtask

    task automatic compare_log(input string tag);
        check_eq({tag, "_count"}, 32'(log_data.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && log_data.size() > 0) begin
            check_eq(tag, 32'(log_data.pop_front()), 32'(exp_q.pop_front()));
        end
        clear_logs();
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        int c0;
        int t_idle;
        int k;

        // Reset values
        step();
        check_eq("rst_tx_data", 32'(tx_data), 32'h00);
        check_eq("rst_tx_we", 32'(tx_we), 32'h0);
        check_eq("rst_grant_id", 32'(grant_id), 32'h0);
        check_eq("rst_drop", 32'(drop), 32'h0);
        check_eq("rst_full", 32'({req1_full, req0_full}), 32'h0);
        check_eq("rst_idle", 32'(idle), 32'h1);
        check_eq("rst_state", 32'(state_dbg), 32'h0);
        resetn = 1'b1;
        step();
        clear_logs();

        // Single byte: issue two cycles after the write, idle one cycle after busy falls
        busy_len = 10;
        c0 = cyc;
        wr0(8'h41);
        exp_q.push_back(8'h41);
        wait_issued(1, 60);
        t_idle = cyc;
        if (log_cyc.size() >= 1) begin
            check_eq("single_latency", 32'(log_cyc[0] - c0), 32'd2);
            check_eq("single_gid", 32'(log_gid[0]), 32'h0);
            check_eq("single_idle_at", 32'(t_idle - log_cyc[0]), 32'd12);
        end
        compare_log("single_data");

        // Round-robin between two preloaded queues
        do_reset();
        busy_len = 0;
        req0_data = 8'h30; req0_we = 1'b1;
        req1_data = 8'h61; req1_we = 1'b1;
        step();
        req0_data = 8'h31;
        req1_data = 8'h62;
        step();
        req0_we = 1'b0;
        req1_we = 1'b0;
        wait_issued(4, 100);
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_q.push_back(8'h30); exp_q.push_back(8'h31);
        exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        if (log_gid.size() == 4) check_eq("rr_gids", 32'({log_gid[0], log_gid[1], log_gid[2], log_gid[3]}), 32'b0011);
`else
        exp_q.push_back(8'h30); exp_q.push_back(8'h61);
        exp_q.push_back(8'h31); exp_q.push_back(8'h62);
        if (log_gid.size() == 4) check_eq("rr_gids", 32'({log_gid[0], log_gid[1], log_gid[2], log_gid[3]}), 32'b0101);
`endif
        compare_log("rr_data");

        // Busy timeout pacing: one issue every BUSY_WAIT+3 cycles
        busy_len = 0;
        c0 = cyc;
        wr0(8'h11);
        wr0(8'h12);
        wr0(8'h13);
        exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
        wait_issued(3, 100);
        if (log_cyc.size() == 3) begin
            check_eq("to_first", 32'(log_cyc[0] - c0), 32'd2);
            check_eq("to_gap1", 32'(log_cyc[1] - log_cyc[0]), 32'd6);
            check_eq("to_gap2", 32'(log_cyc[2] - log_cyc[1]), 32'd6);
            check_eq("to_gid", 32'({log_gid[0], log_gid[1], log_gid[2]}), 32'b000);
        end
        compare_log("to_data");

        // Overflow: FIFO1 fills while a FIFO0 byte holds the UART busy
        busy_len = 20;
        wr0(8'h7E);
        exp_q.push_back(8'h7E);
        k = 0;
        while (log_data.size() == 0 && k < 20) begin
            step();
            k++;
        end
        check_eq("ovf_prime_issued", 32'(log_data.size()), 32'd1);
        wr1(8'h01);
        wr1(8'h02);
        wr1(8'h03);
        check_eq("ovf_full_after3", 32'(req1_full), 32'h0);
        wr1(8'h04);
        check_eq("ovf_full_after4", 32'(req1_full), 32'h1);
        check_eq("ovf_drop_after4", 32'(drop), 32'h0);
        wr1(8'h05);
        check_eq("ovf_full_after5", 32'(req1_full), 32'h1);
        check_eq("ovf_drop_after5", 32'(drop), 32'h2);
        check_eq("ovf_req0_full", 32'(req0_full), 32'h0);
        busy_len = 2;
        wait_issued(5, 300);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        exp_q.push_back(8'h03); exp_q.push_back(8'h04);
        if (log_gid.size() == 5) check_eq("ovf_gids", 32'({log_gid[0], log_gid[1], log_gid[2], log_gid[3], log_gid[4]}), 32'b01111);
        check_eq("ovf_drop_sticky", 32'(drop), 32'h2);
        compare_log("ovf_data");

        // Asynchronous reset in WAIT_FALL with a byte still queued
        busy_len = 10;
        wr1(8'h55);
        k = 0;
        while (state_dbg != 2'd3 && k < 20) begin
            step();
            k++;
        end
        check_eq("ar_in_wait_fall", 32'(state_dbg), 32'h3);
        wr0(8'h66);
        check_eq("ar_pre_state", 32'(state_dbg), 32'h3);
        check_eq("ar_pre_data", 32'(tx_data), 32'h55);
        check_eq("ar_pre_gid", 32'(grant_id), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("ar_tx_we", 32'(tx_we), 32'h0);
        check_eq("ar_idle", 32'(idle), 32'h1);
        check_eq("ar_drop", 32'(drop), 32'h0);
        check_eq("ar_tx_data", 32'(tx_data), 32'h00);
        check_eq("ar_gid", 32'(grant_id), 32'h0);
        check_eq("ar_state", 32'(state_dbg), 32'h0);
        step();
        resetn = 1'b1;
        clear_logs();
        busy_len = 0;
        repeat (30) step();
        check_eq("ar_no_issue", 32'(log_data.size()), 32'd0);
        c0 = cyc;
        wr0(8'h77);
        exp_q.push_back(8'h77);
        wait_issued(1, 50);
        if (log_cyc.size() == 1) check_eq("ar_new_latency", 32'(log_cyc[0] - c0), 32'd2);
        compare_log("ar_new_data");

        // Wrap-around: 12 bytes in groups of three, drained between groups
        busy_len = 1;
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < 3; j++) begin
                wr0(8'(8'hA0 + g * 3 + j));
                exp_q.push_back(8'(8'hA0 + g * 3 + j));
            end
            wait_issued((g + 1) * 3, 100);
        end
        check_eq("wrap_drop", 32'(drop), 32'h0);
        compare_log("wrap_data");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Two-requester byte scheduler for the shared UART transmitter. Each requester has its own small FIFO. The block arbitrates between the two queues, issues one byte at a time to the UART (`reg_dat_di` / `reg_dat_we`) and paces issue using the UART's `tx_busy`. It sits between the CPU core's memory-mapped TX port (requester 0) and a debug/status message source (requester 1) on one side, and the `uart` instance on the other.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: entries per requester FIFO; power of two, ≥2.
- `BUSY_WAIT`, default 3: cycles to wait for `tx_busy` to rise after an issue before treating the byte as sent.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `resetn` in 1: reset; asynchronous, active-low.
- `req0_data` in 8: requester 0 byte.
- `req0_we` in 1: requester 0 write strobe.
- `req0_full` out 1: requester 0 FIFO full.
- `req1_data` in 8: requester 1 byte.
- `req1_we` in 1: requester 1 write strobe.
- `req1_full` out 1: requester 1 FIFO full.
- `tx_data` out 8: byte to the UART; connects to `reg_dat_di`.
- `tx_we` out 1: one-cycle issue pulse; connects to `reg_dat_we`.
- `tx_busy` in 1: UART transmitter busy.
- `grant_id` out 1: requester whose byte was last issued.
- `drop` out 2: sticky overflow flags, bit n = requester n.
- `idle` out 1: FSM is in IDLE and both FIFOs are empty.

## Operation
FIFOs:
- Each requester FIFO is circular with `log2(FIFO_DEPTH)`-bit pointers that wrap naturally, plus a count of width `log2(FIFO_DEPTH)+1`.
- `reqN_full` = (count == `FIFO_DEPTH`), combinational from registered count.
- A write with `reqN_full` high is discarded and sets `drop[N]`. This holds even if the same FIFO is popped in that cycle.
- `drop[N]` stays set until reset.
- A pop and an accepted write in the same cycle leave the count unchanged.

FSM, states IDLE, ISSUE, WAIT_RISE, WAIT_FALL:
- **IDLE**:
  - If either FIFO is non-empty, select a requester, latch its head byte into `tx_data`, pop it, record `grant_id`, then go to ISSUE.
  - If both are non-empty, the requester not recorded in `last_grant` wins.
- **ISSUE**: `tx_we`=1 for exactly this cycle. Load the wait counter with `BUSY_WAIT`. Go to WAIT_RISE.
- **WAIT_RISE**:
  - `tx_busy`=1: go to WAIT_FALL.
  - Otherwise decrement the counter. When the counter reaches 0, go to IDLE; this guards against a missed busy pulse.
- **WAIT_FALL**: when `tx_busy`=0, go to IDLE.
- `tx_data` holds its value from the latch in IDLE until the next latch.
- `last_grant` updates on every grant.

## Timing
Reset values:
- `tx_data`=0, `tx_we`=0, `grant_id`=0.
- `drop`=2'b00, `reqN_full`=0, `idle`=1.
- FIFOs empty, state IDLE.
- `last_grant`=1, so requester 0 wins the first conflict.

Latency and pacing:
- `reqN_we` high in cycle 0 with the FSM idle and both FIFOs empty gives `tx_we` high in cycle 2.
  - Cycle 0: the write is captured.
  - Cycle 1: IDLE sees non-empty and latches.
  - Cycle 2: ISSUE.
- Minimum spacing between issues with no `tx_busy` response is `BUSY_WAIT`+3 cycles.

Reset mid-operation:
- Asserting `resetn` low forces all outputs to their reset values immediately, without waiting for a clock edge.
- Queued bytes are lost.

`tx_busy` handling:
- `tx_busy` is sampled only in WAIT_RISE and WAIT_FALL.
- `tx_busy` high while the FSM is in IDLE does not block issue. The UART rejects or queues per its own rules; the arbiter does not pre-check.

## Configuration
- `UART_ARB_FIXED_PRIO_EN` defined: requester 0 always wins a conflict, and `last_grant` is unused. Requester 1 is served only when FIFO 0 is empty.
- Undefined (default): round-robin as described in Operation.

## Test plan
- **Single byte:** reset, then `req0_we`=1 with `req0_data`=0x41 for one cycle.
  - Required: `tx_we` pulses in cycle 2 with `tx_data`=0x41 and `grant_id`=0.
  - Model `tx_busy` high for 10 cycles starting 1 cycle after the pulse; `idle` returns to 1 the cycle after `tx_busy` falls.
- **Round-robin:** preload FIFO0 with 0x30,0x31 and FIFO1 with 0x61,0x62.
  - Required issue order: 0x30, 0x61, 0x31, 0x62.
  - With `UART_ARB_FIXED_PRIO_EN`: 0x30, 0x31, 0x61, 0x62.
- **Overflow:** write 5 bytes 0x01..0x05 to FIFO1 back-to-back while the first byte holds the UART busy, with `FIFO_DEPTH`=4.
  - Required: `req1_full`=1 after the 4th accepted write, 0x05 is discarded, `drop`=2'b10.
  - Issued bytes are 0x01..0x04 only.
- **Busy timeout:** `tx_busy` tied to 0 and 3 bytes queued.
  - Required: `tx_we` pulses every `BUSY_WAIT`+3=6 cycles and the bytes go out in order.
- **Async reset:** drop `resetn` mid-WAIT_FALL at a point between clock edges.
  - Required: `tx_we`=0, `idle`=1 and `drop`=0 before the next edge.
  - No byte is issued after release until a new write.
- **Wrap-around:** 12 single writes to FIFO0, interleaved with drains.
  - Required: all 12 bytes are issued in order and `drop` stays 0.
